timer_bank: RTL

//  Parametrised multi-channel down-counter/timer peripheral for the CPU I/O bus.

---
 rtl/timer_bank.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module  : timer_bank
// Brief   : N-channel prescaled down-counter timers with one-shot, periodic and
//           square-wave modes, per-channel pending bits and a maskable irq.
// Rev     : 1.0  initial release
// ============================================================================
module timer_bank #(
    parameter int NCH     = 4,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NCH)+1:0]   addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic [NCH-1:0]           tick_out,
    output logic [NCH-1:0]           wave_out,
    output logic                     irq
);

    localparam int AW = $clog2(NCH) + 2;

    localparam logic [1:0] c_reg_load   = 2'd0;
    localparam logic [1:0] c_reg_ctrl   = 2'd1;
    localparam logic [1:0] c_reg_count  = 2'd2;
    localparam logic [1:0] c_reg_status = 2'd3;

    localparam logic [1:0] c_mode_oneshot  = 2'b00;
    localparam logic [1:0] c_mode_periodic = 2'b01;
    localparam logic [1:0] c_mode_square   = 2'b10;
    localparam logic [1:0] c_mode_hold     = 2'b11;

    logic [AW-1:0]             w_ch;
    logic [NCH-1:0][31:0]      w_rd;
    logic [NCH-1:0]            w_irq_src;
    logic                      r_irq;

    assign w_ch = addr >> 2;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0]   r_load;
        logic [WIDTH-1:0]   r_count;
        logic [PRESC_W-1:0] r_presc;
        logic [PRESC_W-1:0] r_pcnt;
        logic [1:0]         r_mode;
        logic               r_en;
        logic               r_ie;
        logic               r_pend;
        logic               r_tick;
        logic               r_wave;

        logic w_hit;
        logic w_wr_load;
        logic w_wr_ctrl;
        logic w_wr_status;
        logic w_active;
        logic w_step;
        logic w_exp;

        assign w_hit       = (w_ch == AW'(i));
        assign w_wr_load   = we && w_hit && (addr[1:0] == c_reg_load);
        assign w_wr_ctrl   = we && w_hit && (addr[1:0] == c_reg_ctrl);
        assign w_wr_status = we && w_hit && (addr[1:0] == c_reg_status);

        assign w_active = r_en && (r_mode != c_mode_hold);
        assign w_step   = w_active && (r_pcnt == r_presc);
        assign w_exp    = w_step && (r_count == '0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_load  <= '0;
                r_count <= '0;
                r_presc <= '0;
                r_pcnt  <= '0;
                r_mode  <= '0;
                r_en    <= 1'b0;
                r_ie    <= 1'b0;
                r_pend  <= 1'b0;
                r_tick  <= 1'b0;
                r_wave  <= 1'b0;
            end else begin
                r_tick <= w_exp;
                if (w_active) begin
                    r_pcnt <= w_step ? '0 : r_pcnt + 1'b1;
                end
                if (w_step) begin
                    if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                    end else begin
                        case (r_mode)
                            c_mode_oneshot:  r_en <= 1'b0;
                            c_mode_periodic: r_count <= r_load;
                            c_mode_square: begin
                                r_count <= r_load;
                                r_wave  <= ~r_wave;
                            end
                            default: ;
                        endcase
                    end
                end
                // An expiry in the same cycle as a clear keeps the bit set.
                if (w_wr_status && wdata[0]) begin
                    r_pend <= 1'b0;
                end
                if (w_exp) begin
                    r_pend <= 1'b1;
                end
                if (w_wr_load) begin
                    r_load  <= wdata[WIDTH-1:0];
                    r_count <= wdata[WIDTH-1:0];
                    r_pcnt  <= '0;
                end
                if (w_wr_ctrl) begin
                    r_en    <= wdata[0];
                    r_mode  <= wdata[2:1];
                    r_ie    <= wdata[3];
                    r_presc <= wdata[8 +: PRESC_W];
                    if (wdata[0] && !r_en) begin
                        r_count <= r_load;
                        r_pcnt  <= '0;
                        r_wave  <= 1'b0;
                    end
                end
            end
        end

        assign w_rd[i] = !w_hit                          ? 32'd0 :
                         (addr[1:0] == c_reg_load)       ? 32'(r_load) :
                         (addr[1:0] == c_reg_ctrl)       ? 32'({r_presc, 4'b0000, r_ie, r_mode, r_en}) :
                         (addr[1:0] == c_reg_count)      ? 32'(r_count) :
                                                           {31'd0, r_pend};

        assign tick_out[i]  = r_tick;
        assign wave_out[i]  = r_wave;
        assign w_irq_src[i] = r_pend && r_ie;
    end

    // Only the addressed in-range channel drives a non-zero word.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NCH; k++) begin
            rdata = rdata | w_rd[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_irq_src;
        end
    end

    assign irq = r_irq;

endmodule
`default_nettype wire
